buck_top: RTL and testbench
===========================

# buck_top

Fixed-point, cycle-stepped simulator of an ideal open-loop buck converter (PWM switch, freewheeling diode, series inductor, output capacitor, resistive load). It is the top level of the buck system. Each clock advances the circuit state by one forward-Euler time step. It exports the switch-node voltage and the output (capacitor) voltage, split into integer and fraction for logging.

## Interface
Parameters:
- VIN, 12: input source voltage in volts, integer, ≤ 15.
- PWM_PERIOD, 100: switching period in steps, 2..255.
- DUTY, 50: on-steps per period, 0..PWM_PERIOD.
- K_L, 131: dt/L as unsigned Q0.16.
- K_C, 655: dt/C as unsigned Q0.16.
- K_R, 66: dt/(R·C) as unsigned Q0.16.

Ports:
- clk_i  in  1  single clock; one simulation step per rising edge.
- rst_i  in  1  synchronous, active-high reset.
- v_1_o  out  4  switch-node voltage, integer volts (VIN or 0).
- v_2i_o  out  16  output voltage, integer part (bits 31:16 of vC).
- v_2d_o  out  16  output voltage, fraction part (bits 15:0 of vC, raw Q0.16 code).

## Operation
- State:
  - cnt, 8-bit PWM counter.
  - iL, signed 32-bit Q16.16 inductor current.
  - vC, signed 32-bit Q16.16 capacitor voltage.
- Switch: sw = (cnt < DUTY). vsw = sw ? VIN<<16 : 0 (Q16.16).
- Each step, all state updates simultaneously from the old values (explicit Euler):
  - iL_next = iL + ((vsw − vC) · K_L) >>> 16
  - vC_next = vC + ((iL · K_C) >>> 16) − ((vC · K_R) >>> 16)
  - Products are full-width signed (32×17-bit signed, K zero-extended). >>> is an arithmetic shift, so results floor toward −∞.
- Diode: if iL_next < 0, store 0. The inductor current never goes negative, which gives discontinuous conduction.
- Saturation: iL_next and vC_next clamp to the signed 32-bit range. No wrap is allowed.
- cnt increments each step and wraps from PWM_PERIOD−1 to 0.
- v_1_o ← sw ? VIN : 0 (registered, same edge as the state update).
- v_2i_o / v_2d_o are direct wires of the registered vC.
- DUTY = 0 gives the switch always off. DUTY = PWM_PERIOD gives it always on.

## Timing
- rst_i high at an edge clears cnt, iL, vC and v_1_o to 0. All outputs read 0 in the following cycle.
- Reset mid-run discards all state on that edge. There is no partial update.
- Edge n (n = 1 is the first edge with rst_i low) uses cnt = (n−1) mod PWM_PERIOD.
- Output latency is one clock from state inputs.
- vC lags iL by one step, because the vC update uses the old iL.
- With defaults:
  - v_1_o = 12 after edges 1..50.
  - v_1_o = 0 after edges 51..100.
  - v_1_o = 12 again after edge 101.
- No handshake. Outputs change every cycle while out of reset.

## Test plan
- Reset: hold rst_i for 3 edges with arbitrary prior state. Required: v_1_o = 0, v_2i_o = 0, v_2d_o = 0, and internal iL = 0.
- First steps, defaults:
  - After edge 1: v_1_o = 12, iL = 1572, vC = 0.
  - After edge 2: iL = 3144, v_2i_o = 0, v_2d_o = 15.
- PWM: track v_1_o over 300 edges. Required: exactly 50 consecutive 12s followed by 50 consecutive 0s, repeating, with the first 0 after edge 51.
- Diode clamp: DUTY = 5, K_L = 655, run 2000 edges. Required: iL never < 0, and iL sits at exactly 0 for part of each off interval.
- Steady state: defaults, run 20000 edges. Required:
  - v_2i_o ∈ {5, 6}, with vC within 6.0 ± 0.5 V (v_2i_o + v_2d_o/65536).
  - No output value ≥ 16 at any point during the run.
- Mid-run reset: assert rst_i for 1 edge at edge 7000, then release. Required: outputs 0 in the next cycle, then the edge-1/edge-2 values above repeat exactly.

Source files
------------

// File: rtl/buck_top.sv
// buck_top: fixed-point forward-Euler simulator of an open-loop buck converter.
// Latency: one clock; state and all outputs update together on each rising edge.
// Backpressure: none; the model advances one time step on every clock out of reset.
module buck_top #(
  parameter int unsigned VIN        = 12,   // source voltage, integer volts (<= 15)
  parameter int unsigned PWM_PERIOD = 100,  // switching period in steps (2..255)
  parameter int unsigned DUTY       = 50,   // on-steps per period (0..PWM_PERIOD)
  parameter int unsigned K_L        = 131,  // dt/L, unsigned Q0.16
  parameter int unsigned K_C        = 655,  // dt/C, unsigned Q0.16
  parameter int unsigned K_R        = 66    // dt/(R*C), unsigned Q0.16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [3:0]  v_1_o,
  output logic [15:0] v_2i_o,
  output logic [15:0] v_2d_o
);

  // Switch-node voltage when the switch conducts, in Q16.16.
  localparam logic signed [31:0] VSW_ON = {12'd0, 4'(VIN), 16'd0};

  // Coefficients zero-extended to 17-bit signed so every product is signed.
  localparam logic signed [16:0] KL_S = {1'b0, 16'(K_L)};
  localparam logic signed [16:0] KC_S = {1'b0, 16'(K_C)};
  localparam logic signed [16:0] KR_S = {1'b0, 16'(K_R)};

  // Clamp bounds for the 32-bit signed state registers.
  localparam logic signed [50:0] SAT_MAX = 51'sd2147483647;
  localparam logic signed [50:0] SAT_MIN = -51'sd2147483648;

  localparam logic [7:0] CNT_LAST = 8'(PWM_PERIOD - 1);
  localparam logic [8:0] DUTY_9   = 9'(DUTY);

  // Saturate a wide intermediate to the signed 32-bit range instead of wrapping.
  function automatic logic signed [31:0] sat32(input logic signed [50:0] x);
    logic signed [31:0] y;
    if (x > SAT_MAX) begin
      y = 32'sh7FFF_FFFF;
    end else if (x < SAT_MIN) begin
      y = 32'sh8000_0000;
    end else begin
      y = x[31:0];
    end
    return y;
  endfunction

  // State
  logic        [7:0]  r_cnt;
  logic signed [31:0] r_il;
  logic signed [31:0] r_vc;
  logic        [3:0]  r_v1;

  // Switch decision and switch-node voltage for this step.
  logic               w_sw;
  logic signed [31:0] w_vsw;

  // Inductor path: (vsw - vC) * K_L, floored by the arithmetic shift.
  logic signed [32:0] w_vdiff;
  logic signed [49:0] w_dil_prod;
  logic signed [49:0] w_dil_sh;
  logic signed [50:0] w_il_sum;
  logic signed [31:0] w_il_sat;
  logic signed [31:0] w_il_next;

  // Capacitor path: charge from old iL, discharge through the load from old vC.
  logic signed [48:0] w_ic_prod;
  logic signed [48:0] w_ic_sh;
  logic signed [48:0] w_ir_prod;
  logic signed [48:0] w_ir_sh;
  logic signed [50:0] w_vc_sum;
  logic signed [31:0] w_vc_next;

  logic        [7:0]  w_cnt_next;

  assign w_sw  = ({1'b0, r_cnt} < DUTY_9);
  assign w_vsw = w_sw ? VSW_ON : 32'sd0;

  assign w_vdiff    = {w_vsw[31], w_vsw} - {r_vc[31], r_vc};
  assign w_dil_prod = w_vdiff * KL_S;
  assign w_dil_sh   = w_dil_prod >>> 16;
  assign w_il_sum   = {{19{r_il[31]}}, r_il} + {w_dil_sh[49], w_dil_sh};
  assign w_il_sat   = sat32(w_il_sum);
  // Freewheeling diode blocks reverse current: negative results store as zero.
  assign w_il_next  = w_il_sat[31] ? 32'sd0 : w_il_sat;

  assign w_ic_prod = r_il * KC_S;
  assign w_ic_sh   = w_ic_prod >>> 16;
  assign w_ir_prod = r_vc * KR_S;
  assign w_ir_sh   = w_ir_prod >>> 16;
  assign w_vc_sum  = {{19{r_vc[31]}}, r_vc}
                   + {{2{w_ic_sh[48]}}, w_ic_sh}
                   - {{2{w_ir_sh[48]}}, w_ir_sh};
  assign w_vc_next = sat32(w_vc_sum);

  assign w_cnt_next = (r_cnt == CNT_LAST) ? 8'd0 : r_cnt + 8'd1;

  // Advance the whole circuit one Euler step from the old state; reset wipes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= 8'd0;
      r_il  <= 32'sd0;
      r_vc  <= 32'sd0;
      r_v1  <= 4'd0;
    end else begin
      r_cnt <= w_cnt_next;
      r_il  <= w_il_next;
      r_vc  <= w_vc_next;
      r_v1  <= w_sw ? 4'(VIN) : 4'd0;
    end
  end

  assign v_1_o  = r_v1;
  assign v_2i_o = r_vc[31:16];
  assign v_2d_o = r_vc[15:0];

endmodule

// File: tb/tb_buck_top.sv
// tb_buck_top: directed checks of the buck converter simulator.
// Default instance covers reset, first steps, PWM pattern, mid-run reset and
// steady state; a second instance (DUTY=5, K_L=655) covers diode clamping.
module tb_buck_top;

  logic        clk_i;
  logic        rst_a;
  logic        rst_b;
  logic [3:0]  v1_a;
  logic [15:0] v2i_a;
  logic [15:0] v2d_a;
  logic [3:0]  v1_b;
  logic [15:0] v2i_b;
  logic [15:0] v2d_b;

  int n_vec  = 0;
  int n_miss = 0;

  buck_top dut_a (
    .clk_i  (clk_i),
    .rst_i  (rst_a),
    .v_1_o  (v1_a),
    .v_2i_o (v2i_a),
    .v_2d_o (v2d_a)
  );

  buck_top #(.DUTY(5), .K_L(655)) dut_b (
    .clk_i  (clk_i),
    .rst_i  (rst_b),
    .v_1_o  (v1_b),
    .v_2i_o (v2i_b),
    .v_2d_o (v2d_b)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every vector, reports any miscompare.
  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle before anything is sampled or driven.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Hand-computed values for the first three steps with default parameters.
  task automatic check_first(input int n);
    logic [31:0] vc;
    vc = {v2i_a, v2d_a};
    if (n == 1) begin
      chk("e1_v1", v1_a, 12);
      chk("e1_il", dut_a.r_il, 1572);
      chk("e1_vc", vc, 0);
    end else if (n == 2) begin
      chk("e2_il", dut_a.r_il, 3144);
      chk("e2_v2i", v2i_a, 0);
      chk("e2_v2d", v2d_a, 15);
    end else if (n == 3) begin
      chk("e3_il", dut_a.r_il, 4715);
      chk("e3_vc", vc, 46);
    end
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_v1"}, v1_a, 0);
    chk({tag, "_v2i"}, v2i_a, 0);
    chk({tag, "_v2d"}, v2d_a, 0);
    chk({tag, "_il"}, dut_a.r_il, 0);
  endtask

  initial begin
    int          max_out;
    bit          b_neg;
    int          zero_cnt;
    int          c;
    logic [31:0] vc;

    max_out  = 0;
    b_neg    = 1'b0;
    zero_cnt = 0;

    // Build up arbitrary non-zero state, then hold reset for three edges.
    rst_a = 1'b1;
    rst_b = 1'b1;
    step();
    rst_a = 1'b0;
    for (int i = 0; i < 37; i++) step();
    rst_a = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_reset_zero("rst");

    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int n = 1; n < 7000; n++) begin
      step();
      check_first(n);
      if (n <= 300) chk("pwm", v1_a, (((n - 1) % 100) < 50) ? 12 : 0);
      if (int'(v2i_a) > max_out) max_out = int'(v2i_a);
      if (int'(v1_a) > max_out) max_out = int'(v1_a);

      // Diode instance: first-step current, no negative current, and zero
      // current for part of every off interval once the start-up has settled.
      if (n <= 2000) begin
        if (n == 1) chk("b_e1_il", dut_b.r_il, 7860);
        if (dut_b.r_il < 0) b_neg = 1'b1;
        c = (n - 1) % 100;
        if (c == 0) zero_cnt = 0;
        if (c >= 5 && dut_b.r_il == 0) zero_cnt++;
        if (n > 1000 && c == 99) chk("b_dcm_zero", (zero_cnt > 0) ? 1 : 0, 1);
      end
    end
    chk("b_il_nonneg", b_neg ? 1 : 0, 0);

    // Single-edge reset at edge 7000, then the opening steps must repeat.
    rst_a = 1'b1;
    step();
    check_reset_zero("midrst");
    rst_a = 1'b0;
    for (int n = 1; n <= 20000; n++) begin
      step();
      check_first(n);
      if (int'(v2i_a) > max_out) max_out = int'(v2i_a);
      if (int'(v1_a) > max_out) max_out = int'(v1_a);
    end

    // Steady state near D*VIN = 6 V.
    vc = {v2i_a, v2d_a};
    chk("ss_int", (v2i_a == 16'd5 || v2i_a == 16'd6) ? 1 : 0, 1);
    chk("ss_vc_window", (vc >= 32'd360448 && vc <= 32'd425984) ? 1 : 0, 1);
    chk("max_below_16", (max_out < 16) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
